// File: rtl/sys_top_pkg.sv
// Shared constants, opcodes and state encodings for the sys_top UART register block.
// The read command path is enabled by defining SYS_TOP_READ_CMD_EN.
package sys_top_pkg;

    localparam int unsigned PRESCALE  = 32;
    localparam int unsigned REG_DEPTH = 16;
    localparam int unsigned CFG_ADDR  = 2;
    localparam int unsigned CNT_W     = $clog2(PRESCALE);
    localparam int unsigned HALF_BIT  = PRESCALE / 2;
    localparam int unsigned ADDR_W    = $clog2(REG_DEPTH);

    localparam logic [7:0] WR_CMD    = 8'hAA;
    localparam logic [7:0] RD_CMD    = 8'hBB;
    localparam logic [7:0] CFG_RESET = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT
    } cmd_state_e;

    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_PAR,
        BIT_STOP
    } bit_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 32x oversampled, one mid-bit sample, optional parity latched per frame.
// Emits a one-cycle valid pulse for a good frame or an error pulse for a bad one.
module uart_rx
    import sys_top_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_i,
    input  logic                  par_en_i,
    input  logic                  par_odd_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  err_o
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [1:0]            sync_q;
    bit_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  pen_q, pen_d;
    logic                  podd_q, podd_d;
    logic                  perr_q, perr_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  rx;
    logic                  mid;
    logic                  last;

    assign rx   = sync_q[1];
    assign mid  = (cnt_q == CNT_W'(HALF_BIT));
    assign last = (cnt_q == CNT_W'(PRESCALE - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        perr_d  = perr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            BIT_IDLE: begin
                cnt_d = '0;
                // Parity config is captured here so a config write mid-frame cannot affect it.
                if (!rx) begin
                    state_d = BIT_START;
                    pen_d   = par_en_i;
                    podd_d  = par_odd_i;
                    perr_d  = 1'b0;
                end
            end
            BIT_START: begin
                if (mid && rx) begin
                    state_d = BIT_IDLE;
                end else if (last) begin
                    state_d = BIT_DATA;
                    idx_d   = '0;
                end
            end
            BIT_DATA: begin
                if (mid) begin
                    shift_d = {rx, shift_q[DATA_WIDTH-1:1]};
                end
                if (last) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = pen_q ? BIT_PAR : BIT_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            BIT_PAR: begin
                if (mid) begin
                    perr_d = (rx != ((^shift_q) ^ podd_q));
                end
                if (last) begin
                    state_d = BIT_STOP;
                end
            end
            BIT_STOP: begin
                // Frame is resolved at mid-stop so the next start edge is never missed.
                if (mid) begin
                    state_d = BIT_IDLE;
                    if (!rx || perr_q) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = BIT_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            state_q <= BIT_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            perr_q  <= perr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_o  = shift_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/sys_top.sv
// UART-controlled 16-entry register file with write command, config register 2 for parity,
// and an optional read-back transmitter enabled by defining SYS_TOP_READ_CMD_EN.
module sys_top
    import sys_top_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic UART_CLK,
    input  logic RST,
    input  logic RX_IN,
    output logic TX_OUT,
    output logic RX_ERROR
);

    logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];
    cmd_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rx_error_q;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_err;
    logic                  par_en;
    logic                  par_odd;
    logic                  addr_ok;

    assign par_en  = regs_q[CFG_ADDR][0];
    assign par_odd = regs_q[CFG_ADDR][1];
    assign addr_ok = ((addr_q >> ADDR_W) == '0);

    uart_rx #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rx (
        .clk_i    (UART_CLK),
        .rst_ni   (RST),
        .rx_i     (RX_IN),
        .par_en_i (par_en),
        .par_odd_i(par_odd),
        .data_o   (rx_data),
        .valid_o  (rx_valid),
        .err_o    (rx_err)
    );

`ifdef SYS_TOP_READ_CMD_EN
    bit_state_e            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [3:0]            tx_idx_q, tx_idx_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_pen_q, tx_pen_d;
    logic                  tx_par_q, tx_par_d;
    logic                  tx_out_q, tx_out_d;
    logic                  tx_load;
    logic                  tx_idle;
    logic [DATA_WIDTH-1:0] rd_data;

    assign tx_idle = (tx_state_q == BIT_IDLE);
    assign rd_data = addr_ok ? regs_q[addr_q[ADDR_W-1:0]] : '0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
`ifdef SYS_TOP_READ_CMD_EN
        tx_load = 1'b0;
`endif
        if (rx_err) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == DATA_WIDTH'(WR_CMD)) begin
                            state_d = WR_ADDR;
`ifdef SYS_TOP_READ_CMD_EN
                        end else if (rx_data == DATA_WIDTH'(RD_CMD)) begin
                            state_d = RD_ADDR;
`endif
                        end
                    end
                end
                WR_ADDR: begin
                    if (rx_valid) begin
                        addr_d  = rx_data;
                        state_d = WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (rx_valid) begin
                        wdata_d = rx_data;
                        wr_en_d = 1'b1;
                        state_d = IDLE;
                    end
                end
`ifdef SYS_TOP_READ_CMD_EN
                RD_ADDR: begin
                    if (rx_valid) begin
                        addr_d  = rx_data;
                        state_d = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (tx_idle) begin
                        tx_load = 1'b1;
                        state_d = IDLE;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge UART_CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rx_error_q <= 1'b0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                regs_q[i] <= (i == CFG_ADDR) ? DATA_WIDTH'(CFG_RESET) : '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            if (rx_err) begin
                rx_error_q <= 1'b1;
            end else if (rx_valid) begin
                rx_error_q <= 1'b0;
            end
            if (wr_en_q && addr_ok) begin
                regs_q[addr_q[ADDR_W-1:0]] <= wdata_q;
            end
        end
    end

    assign RX_ERROR = rx_error_q;

`ifdef SYS_TOP_READ_CMD_EN
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_pen_d   = tx_pen_q;
        tx_par_d   = tx_par_q;
        case (tx_state_q)
            BIT_IDLE: begin
                tx_cnt_d = '0;
                if (tx_load) begin
                    tx_state_d = BIT_START;
                    tx_shift_d = rd_data;
                    tx_pen_d   = par_en;
                    tx_par_d   = (^rd_data) ^ par_odd;
                end
            end
            BIT_START: begin
                if (tx_cnt_q == CNT_W'(PRESCALE - 1)) begin
                    tx_state_d = BIT_DATA;
                    tx_idx_d   = '0;
                end
            end
            BIT_DATA: begin
                if (tx_cnt_q == CNT_W'(PRESCALE - 1)) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_idx_q == 4'(DATA_WIDTH - 1)) begin
                        tx_state_d = tx_pen_q ? BIT_PAR : BIT_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                    end
                end
            end
            BIT_PAR: begin
                if (tx_cnt_q == CNT_W'(PRESCALE - 1)) begin
                    tx_state_d = BIT_STOP;
                end
            end
            BIT_STOP: begin
                if (tx_cnt_q == CNT_W'(PRESCALE - 1)) begin
                    tx_state_d = BIT_IDLE;
                end
            end
            default: tx_state_d = BIT_IDLE;
        endcase
        // Line level is derived from the next state so TX_OUT stays a clean register output.
        case (tx_state_d)
            BIT_START: tx_out_d = 1'b0;
            BIT_DATA:  tx_out_d = tx_shift_d[0];
            BIT_PAR:   tx_out_d = tx_par_d;
            default:   tx_out_d = 1'b1;
        endcase
    end

    always_ff @(posedge UART_CLK) begin
        if (!RST) begin
            tx_state_q <= BIT_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_pen_q   <= 1'b0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_pen_q   <= tx_pen_d;
            tx_par_q   <= tx_par_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign TX_OUT = tx_out_q;
`else
    assign TX_OUT = 1'b1;
`endif

endmodule

// File: tb/tb_sys_top.sv
// Directed bench for sys_top: write/read commands, parity errors, config change, glitch and reset.
// The read-back section is built only when SYS_TOP_READ_CMD_EN is defined.
module tb_sys_top;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    logic tx;
    logic rx_err;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  exp_regs [16];
    logic [10:0] tx_bits;
    logic        tx_seen;
    logic        tx_low;

    always #5 clk = ~clk;

    sys_top #(
        .DATA_WIDTH(8)
    ) dut (
        .UART_CLK(clk),
        .RST     (rst_n),
        .RX_IN   (rx),
        .TX_OUT  (tx),
        .RX_ERROR(rx_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic odd,
                              input logic flip_par, input logic stop_bit);
        rx = 1'b0;
        wait_cyc(32);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(32);
        end
        if (pen) begin
            rx = (^d) ^ odd ^ flip_par;
            wait_cyc(32);
        end
        rx = stop_bit;
        wait_cyc(32);
        rx = 1'b1;
        wait_cyc(32);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, exp_regs[2][0], exp_regs[2][1], 1'b0, 1'b1);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        exp_regs[2] = 8'h01;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_r%0d", tag, i), dut.regs_q[i], exp_regs[i]);
        end
    endtask

    task automatic capture_tx();
        tx_seen = 1'b0;
        tx_bits = '1;
        for (int i = 0; i < 3000 && !tx_seen; i++) begin
            @(negedge clk);
            if (tx == 1'b0) tx_seen = 1'b1;
        end
        if (tx_seen) begin
            wait_cyc(16);
            for (int j = 0; j < 11; j++) begin
                tx_bits[j] = tx;
                wait_cyc(32);
            end
        end
    endtask

    initial begin
        rx    = 1'b1;
        rst_n = 1'b0;
        reset_model();
        wait_cyc(3);
        check("rst_tx", tx, 1);
        check("rst_err", rx_err, 0);
        rst_n = 1'b1;
        wait_cyc(2);
        check_regs("rst");

        // Basic write with even parity
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'hA6);
        exp_regs[5] = 8'hA6;
        wait_cyc(4);
        check("wr5_err", rx_err, 0);
        check_regs("wr5");

`ifdef SYS_TOP_READ_CMD_EN
        send_byte(8'hBB);
        fork
            send_byte(8'h05);
            capture_tx();
        join
        check("rd_seen", tx_seen, 1);
        check("rd_start", tx_bits[0], 0);
        check("rd_data", tx_bits[8:1], 8'hA6);
        check("rd_par", tx_bits[9], 0);
        check("rd_stop", tx_bits[10], 1);
        check("rd_idle", tx, 1);
`else
        send_byte(8'hBB);
        tx_low = 1'b0;
        fork
            send_byte(8'h05);
            begin
                repeat (600) begin
                    @(negedge clk);
                    if (tx == 1'b0) tx_low = 1'b1;
                end
            end
        join
        check("no_rd_tx", tx_low, 0);
`endif
        check_regs("post_rd");

        // Bad parity inside a write command aborts it; following bytes are ignored
        send_byte(8'hAA);
        send_frame(8'h05, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_cyc(4);
        check("par_err_set", rx_err, 1);
        send_byte(8'h05);
        send_byte(8'h77);
        wait_cyc(4);
        check("par_err_clr", rx_err, 0);
        check_regs("par");

        // Stop bit sampled 0 is an error
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(4);
        check("stop_err", rx_err, 1);

        // Switch to odd parity, then write under it
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h03);
        exp_regs[2] = 8'h03;
        send_byte(8'hAA);
        send_byte(8'h07);
        send_byte(8'h11);
        exp_regs[7] = 8'h11;
        wait_cyc(4);
        check("odd_err", rx_err, 0);
        check_regs("odd");

        // Address boundaries: 0x10 dropped, 0x0F written
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h0F);
        send_byte(8'h3C);
        exp_regs[15] = 8'h3C;
        wait_cyc(4);
        check_regs("bound");

        // Short low glitch while a command is pending
        send_byte(8'hAA);
        rx = 1'b0;
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(100);
        check("glitch_err", rx_err, 0);
        send_byte(8'h08);
        send_byte(8'h5A);
        exp_regs[8] = 8'h5A;
        wait_cyc(4);
        check("glitch_err2", rx_err, 0);
        check_regs("glitch");

        // Reset in the middle of a frame
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_cyc(4);
        check("pre_rst_err", rx_err, 1);
        send_byte(8'hAA);
        rx = 1'b0;
        wait_cyc(32 * 4);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cyc(3);
        reset_model();
        check("mid_rst_tx", tx, 1);
        check("mid_rst_err", rx_err, 0);
        rst_n = 1'b1;
        wait_cyc(2);
        check_regs("mid_rst");
        send_byte(8'hAA);
        send_byte(8'h03);
        send_byte(8'hC3);
        exp_regs[3] = 8'hC3;
        wait_cyc(4);
        check("post_rst_err", rx_err, 0);
        check_regs("post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
